// File: rtl/bus_mastership_arbiter.sv
// ---------------------------------------------------------------------------
// bus_mastership_arbiter
//
// Takes the 68k bus away from the CPU on behalf of the bus-cycle engine,
// using the BR / BG / BGACK handshake. Grant is handed to the engine only
// once the CPU has left the bus (AS and BGACK both released), and BGACK is
// asserted one SYSCLK before GRANT so the bus is claimed before the engine
// can start a cycle.
//
// Parameters
//   BG_TIMEOUT    MCCLK_FALLING strobes to wait for BG before giving up (1..255)
//   IDLE_HOLD     MCCLK_FALLING strobes ownership is kept after REQ falls (1..255)
//
// Ports
//   SYSCLK        in   system clock (only clock)
//   nRESET        in   synchronous active-low reset
//   MCCLK_FALLING in   one-SYSCLK strobe per 7 MHz falling edge
//   REQ           in   level request from the bus-cycle engine
//   nBG_IN        in   raw 68k bus grant (asynchronous)
//   nAS_IN        in   raw 68k address strobe (asynchronous)
//   nBGACK_IN     in   raw bus grant acknowledge (asynchronous)
//   FORCE_RELEASE in   one-SYSCLK pulse: abandon / release the bus
//   CLEAR_ERR     in   one-SYSCLK pulse: clear TIMEOUT
//   BR_DRIVE      out  1 = pull nBR low
//   BGACK_DRIVE   out  1 = pull nBGACK low
//   GRANT         out  1 = engine may run bus cycles
//   TIMEOUT       out  sticky grant-timeout flag
//   STATE         out  current state (IDLE=0 .. RELEASE=5)
//
// Build option
//   BUS_HOLD_EN   when defined, ownership lingers in HOLD for IDLE_HOLD
//                 strobes after REQ falls so a quick new request skips
//                 re-arbitration; when undefined OWN goes straight to RELEASE.
// ---------------------------------------------------------------------------
module bus_mastership_arbiter #(
    parameter int unsigned BG_TIMEOUT = 255,
    parameter int unsigned IDLE_HOLD  = 16
) (
    input  logic       SYSCLK,
    input  logic       nRESET,
    input  logic       MCCLK_FALLING,
    input  logic       REQ,
    input  logic       nBG_IN,
    input  logic       nAS_IN,
    input  logic       nBGACK_IN,
    input  logic       FORCE_RELEASE,
    input  logic       CLEAR_ERR,
    output logic       BR_DRIVE,
    output logic       BGACK_DRIVE,
    output logic       GRANT,
    output logic       TIMEOUT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQUEST  = 3'd1,
        S_WAIT_BUS = 3'd2,
        S_OWN      = 3'd3,
        S_HOLD     = 3'd4,
        S_RELEASE  = 3'd5
    } state_t;

    localparam logic [7:0] BG_LIMIT   = 8'(BG_TIMEOUT);
    localparam logic [7:0] HOLD_LIMIT = 8'(IDLE_HOLD);

    // 8-bit counters stick at 255 rather than wrapping back to 0.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic       nbg_p0, nbg_p1;
    logic       nas_p0, nas_p1;
    logic       nbgack_p0, nbgack_p1;

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic [7:0] hold_cnt, hold_cnt_next;
    logic       timeout_q;
    logic       set_timeout;
    logic       grant_q;

    // Stage p0/p1: two-flop synchronizers for the asynchronous 68k signals.
    // They idle high (deasserted) so reset never looks like a grant.
    always_ff @(posedge SYSCLK) begin
        if (!nRESET) begin
            nbg_p0    <= 1'b1;
            nbg_p1    <= 1'b1;
            nas_p0    <= 1'b1;
            nas_p1    <= 1'b1;
            nbgack_p0 <= 1'b1;
            nbgack_p1 <= 1'b1;
        end else begin
            nbg_p0    <= nBG_IN;
            nbg_p1    <= nbg_p0;
            nas_p0    <= nAS_IN;
            nas_p1    <= nas_p0;
            nbgack_p0 <= nBGACK_IN;
            nbgack_p1 <= nbgack_p0;
        end
    end

    // State and control registers.
    always_ff @(posedge SYSCLK) begin
        if (!nRESET) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
            grant_q   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            hold_cnt <= hold_cnt_next;
            // GRANT trails entry into OWN by one cycle so BGACK is already
            // on the bus before the engine starts driving cycles.
            grant_q  <= (state == S_OWN) && (state_next == S_OWN);
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end else if (CLEAR_ERR) begin
                timeout_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        hold_cnt_next = '0;
        set_timeout   = 1'b0;
        BR_DRIVE      = 1'b0;
        BGACK_DRIVE   = 1'b0;

        case (state)
            S_IDLE: begin
                wait_cnt_next = '0;
                if (REQ) begin
                    state_next = S_REQUEST;
                end
            end

            S_REQUEST: begin
                BR_DRIVE = 1'b1;
                if (!REQ || FORCE_RELEASE) begin
                    state_next = S_IDLE;
                end else if (MCCLK_FALLING) begin
                    wait_cnt_next = sat_inc(wait_cnt);
                    if (!nbg_p1) begin
                        state_next = S_WAIT_BUS;
                    end else if (sat_inc(wait_cnt) >= BG_LIMIT) begin
                        set_timeout = 1'b1;
                        state_next  = S_IDLE;
                    end
                end
            end

            S_WAIT_BUS: begin
                BR_DRIVE = 1'b1;
                // The wait counter is frozen here; a withdrawn BG resumes
                // counting in REQUEST from where it left off.
                if (!REQ || FORCE_RELEASE) begin
                    state_next = S_IDLE;
                end else if (nbg_p1) begin
                    state_next = S_REQUEST;
                end else if (MCCLK_FALLING && nas_p1 && nbgack_p1) begin
                    state_next = S_OWN;
                end
            end

            S_OWN: begin
                BGACK_DRIVE = 1'b1;
                // FORCE_RELEASE is ignored while REQ is high: the engine may
                // be mid-cycle. With REQ low it skips the hold period.
                if (!REQ) begin
`ifdef BUS_HOLD_EN
                    state_next = FORCE_RELEASE ? S_RELEASE : S_HOLD;
`else
                    state_next = S_RELEASE;
`endif
                end
            end

            S_HOLD: begin
                BGACK_DRIVE   = 1'b1;
                hold_cnt_next = hold_cnt;
                if (FORCE_RELEASE) begin
                    state_next = S_RELEASE;
                end else if (REQ) begin
                    state_next = S_OWN;
                end else if (MCCLK_FALLING) begin
                    hold_cnt_next = sat_inc(hold_cnt);
                    if (sat_inc(hold_cnt) >= HOLD_LIMIT) begin
                        state_next = S_RELEASE;
                    end
                end
            end

            S_RELEASE: begin
                // A new REQ is picked up from IDLE, never from here.
                if (MCCLK_FALLING) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign GRANT   = grant_q;
    assign TIMEOUT = timeout_q;
    assign STATE   = state;

endmodule

// File: tb/tb_bus_mastership_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_mastership_arbiter
//
// Scoreboard bench: the driver applies stimulus, advances a behavioural
// reference model on every SYSCLK edge and queues the expected outputs; a
// monitor on the falling edge pops and compares. Directed sequences cover
// grant, timeout, WAIT_BUS stall, forced release and reset; a randomized
// phase follows.
// ---------------------------------------------------------------------------
module tb_bus_mastership_arbiter;

    localparam int BG_TO     = 8;
    localparam int IH        = 4;
    localparam int MC_PERIOD = 4;

    logic       SYSCLK        = 1'b0;
    logic       nRESET        = 1'b0;
    logic       MCCLK_FALLING = 1'b0;
    logic       REQ           = 1'b0;
    logic       nBG_IN        = 1'b1;
    logic       nAS_IN        = 1'b1;
    logic       nBGACK_IN     = 1'b1;
    logic       FORCE_RELEASE = 1'b0;
    logic       CLEAR_ERR     = 1'b0;
    logic       BR_DRIVE;
    logic       BGACK_DRIVE;
    logic       GRANT;
    logic       TIMEOUT;
    logic [2:0] STATE;

    bus_mastership_arbiter #(
        .BG_TIMEOUT (BG_TO),
        .IDLE_HOLD  (IH)
    ) dut (
        .SYSCLK        (SYSCLK),
        .nRESET        (nRESET),
        .MCCLK_FALLING (MCCLK_FALLING),
        .REQ           (REQ),
        .nBG_IN        (nBG_IN),
        .nAS_IN        (nAS_IN),
        .nBGACK_IN     (nBGACK_IN),
        .FORCE_RELEASE (FORCE_RELEASE),
        .CLEAR_ERR     (CLEAR_ERR),
        .BR_DRIVE      (BR_DRIVE),
        .BGACK_DRIVE   (BGACK_DRIVE),
        .GRANT         (GRANT),
        .TIMEOUT       (TIMEOUT),
        .STATE         (STATE)
    );

    always #5 SYSCLK = ~SYSCLK;

    int         n_checks = 0;
    int         n_err    = 0;
    int         mc_cnt   = 0;
    logic [6:0] exp_q[$];
    logic [6:0] mon_exp;

    // Reference model: mode numbers are the architectural state values.
    int m_mode  = 0;
    int m_wait  = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;
    bit m_grant = 1'b0;
    bit bg_new  = 1'b1, bg_old  = 1'b1;
    bit as_new  = 1'b1, as_old  = 1'b1;
    bit ack_new = 1'b1, ack_old = 1'b1;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        int prev;
        int nxt;
        bit sbg, sas, sack, to_set;
        if (!nRESET) begin
            m_mode = 0; m_wait = 0; m_hold = 0; m_to = 1'b0; m_grant = 1'b0;
            bg_new = 1'b1; bg_old = 1'b1;
            as_new = 1'b1; as_old = 1'b1;
            ack_new = 1'b1; ack_old = 1'b1;
            return;
        end
        // Decisions see the raw inputs as they were two edges ago.
        sbg = bg_old; sas = as_old; sack = ack_old;
        bg_old = bg_new;   bg_new = nBG_IN;
        as_old = as_new;   as_new = nAS_IN;
        ack_old = ack_new; ack_new = nBGACK_IN;

        prev   = m_mode;
        nxt    = m_mode;
        to_set = 1'b0;
        if (m_mode == 0) begin
            if (REQ) begin
                nxt = 1;
                m_wait = 0;
            end
        end else if (m_mode == 1) begin
            if (!REQ || FORCE_RELEASE) nxt = 0;
            else if (MCCLK_FALLING) begin
                m_wait = (m_wait < 255) ? m_wait + 1 : 255;
                if (!sbg) nxt = 2;
                else if (m_wait >= BG_TO) begin
                    to_set = 1'b1;
                    nxt = 0;
                end
            end
        end else if (m_mode == 2) begin
            if (!REQ || FORCE_RELEASE) nxt = 0;
            else if (sbg) nxt = 1;
            else if (MCCLK_FALLING && sas && sack) nxt = 3;
        end else if (m_mode == 3) begin
            if (!REQ) begin
`ifdef BUS_HOLD_EN
                nxt = FORCE_RELEASE ? 5 : 4;
                m_hold = 0;
`else
                nxt = 5;
`endif
            end
        end else if (m_mode == 4) begin
            if (FORCE_RELEASE) nxt = 5;
            else if (REQ) nxt = 3;
            else if (MCCLK_FALLING) begin
                m_hold++;
                if (m_hold >= IH) nxt = 5;
            end
        end else if (m_mode == 5) begin
            if (MCCLK_FALLING) nxt = 0;
        end
        m_grant = (prev == 3) && (nxt == 3);
        if (to_set) m_to = 1'b1;
        else if (CLEAR_ERR) m_to = 1'b0;
        m_mode = nxt;
    endfunction

    function automatic logic [6:0] model_out();
        logic br, ack;
        br  = (m_mode == 1) || (m_mode == 2);
        ack = (m_mode == 3) || (m_mode == 4);
        return {br, ack, m_grant, m_to, 3'(m_mode)};
    endfunction

    // One SYSCLK: advance the model at the edge, queue its prediction, then
    // retire one-shot pulses and generate the MC strobe for the next edge.
    task automatic cyc();
        @(posedge SYSCLK);
        model_step();
        exp_q.push_back(model_out());
        #1;
        FORCE_RELEASE = 1'b0;
        CLEAR_ERR     = 1'b0;
        mc_cnt++;
        MCCLK_FALLING = ((mc_cnt % MC_PERIOD) == 0);
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int limit, input string name);
        int i;
        i = 0;
        while (i < limit && STATE !== tgt) begin
            cyc();
            i++;
        end
        chk(name, {4'b0, STATE}, {4'b0, tgt});
    endtask

    always @(negedge SYSCLK) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            chk("scoreboard", {BR_DRIVE, BGACK_DRIVE, GRANT, TIMEOUT, STATE}, mon_exp);
            chk("drive_exclusive", {6'b0, BR_DRIVE & BGACK_DRIVE}, 7'd0);
            if (GRANT === 1'b1) chk("grant_only_in_own", {4'b0, STATE}, 7'd3);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset
        nRESET = 1'b0;
        repeat (3) cyc();
        chk("reset_outputs", {BR_DRIVE, BGACK_DRIVE, GRANT, TIMEOUT, STATE}, 7'd0);
        nRESET = 1'b1;
        cyc();

        // Normal acquisition: BG after 3 strobes, CPU off the bus
        REQ = 1'b1;
        wait_state(3'd1, 10, "enter_request");
        chk("br_in_request", {6'b0, BR_DRIVE}, 7'd1);
        repeat (3 * MC_PERIOD) cyc();
        nBG_IN = 1'b0;
        wait_state(3'd3, 40, "reach_own");
        chk("own_entry", {BR_DRIVE, BGACK_DRIVE, GRANT}, 7'b0000_010);
        cyc();
        chk("grant_after_bgack", {6'b0, GRANT}, 7'd1);

        // FORCE_RELEASE while the engine still requests is ignored
        FORCE_RELEASE = 1'b1;
        cyc();
        chk("force_ignored_state", {4'b0, STATE}, 7'd3);
        chk("force_ignored_grant", {6'b0, GRANT}, 7'd1);

`ifdef BUS_HOLD_EN
        // Quick re-request inside the hold window keeps the bus
        REQ = 1'b0;
        cyc();
        chk("hold_entry", {4'b0, STATE}, 7'd4);
        n = 0;
        while (n < 2) begin
            if (MCCLK_FALLING) n++;
            cyc();
            chk("hold_bgack", {6'b0, BGACK_DRIVE}, 7'd1);
        end
        REQ = 1'b1;
        cyc();
        chk("hold_back_own", {4'b0, STATE}, 7'd3);
        chk("hold_back_bgack", {6'b0, BGACK_DRIVE}, 7'd1);
        cyc();
        chk("hold_back_grant", {6'b0, GRANT}, 7'd1);
        REQ = 1'b0;
        wait_state(3'd0, 60, "hold_to_idle");
`else
        REQ = 1'b0;
        cyc();
        chk("direct_release", {4'b0, STATE}, 7'd5);
        chk("release_bgack", {6'b0, BGACK_DRIVE}, 7'd0);
        wait_state(3'd0, 20, "release_to_idle");
`endif

        // Grant never comes: timeout after BG_TO strobes in REQUEST
        nBG_IN = 1'b1;
        repeat (3) cyc();
        REQ = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (TIMEOUT === 1'b1) break;
            if (MCCLK_FALLING && STATE == 3'd1) n++;
            cyc();
        end
        chk("timeout_set", {6'b0, TIMEOUT}, 7'd1);
        chk("timeout_state", {4'b0, STATE}, 7'd0);
        chk("strobes_to_timeout", 7'(n), 7'(BG_TO));
        REQ = 1'b0;
        cyc();
        chk("timeout_sticky", {6'b0, TIMEOUT}, 7'd1);
        CLEAR_ERR = 1'b1;
        cyc();
        chk("timeout_cleared", {6'b0, TIMEOUT}, 7'd0);

        // BG granted but CPU still has AS low: stall in WAIT_BUS
        nBG_IN = 1'b0;
        nAS_IN = 1'b0;
        repeat (3) cyc();
        REQ = 1'b1;
        wait_state(3'd2, 20, "wait_bus_entry");
        n = 0;
        while (n < 5) begin
            if (MCCLK_FALLING) n++;
            cyc();
            chk("as_stall_state", {4'b0, STATE}, 7'd2);
            chk("as_stall_bgack", {6'b0, BGACK_DRIVE}, 7'd0);
        end
        nAS_IN = 1'b1;
        wait_state(3'd3, 20, "own_after_as");
        cyc();

        // Reset while owning the bus
        nRESET = 1'b0;
        cyc();
        chk("reset_in_own", {BR_DRIVE, BGACK_DRIVE, GRANT, TIMEOUT, STATE}, 7'd0);
        cyc();
        chk("reset_held", {BR_DRIVE, BGACK_DRIVE, GRANT, TIMEOUT, STATE}, 7'd0);
        REQ    = 1'b0;
        nRESET = 1'b1;
        cyc();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) REQ = ~REQ;
            if ($urandom_range(7) == 0) nBG_IN = ~nBG_IN;
            if ($urandom_range(3) == 0) nAS_IN = ~nAS_IN;
            nBGACK_IN     = ($urandom_range(9) != 0);
            FORCE_RELEASE = ($urandom_range(39) == 0);
            CLEAR_ERR     = ($urandom_range(29) == 0);
            nRESET        = ($urandom_range(299) != 0);
            cyc();
        end
        nRESET = 1'b1;
        cyc();
        @(negedge SYSCLK);
        @(negedge SYSCLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
